// File: rtl/sample_dump_tx.sv
// Streams a framed dump of the circular sample memory (header, 16-bit count, samples) to a UART byte port.
// Optional trailing XOR checksum byte is enabled by defining SAMPLE_DUMP_CHECKSUM_EN.
module sample_dump_tx #(
  parameter int          ADDR_W = 12,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              activate,
  output logic              done,
  input  logic [15:0]       sample_count,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [3:0]        dbg_main_state,
  output logic [1:0]        dbg_send_state
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_HEADER = 4'd1,
    ST_LEN_HI = 4'd2,
    ST_LEN_LO = 4'd3,
    ST_FETCH  = 4'd4,
    ST_DATA   = 4'd5,
    ST_DONE   = 4'd6
`ifdef SAMPLE_DUMP_CHECKSUM_EN
    , ST_CSUM = 4'd7
`endif
  } main_state_t;

  typedef enum logic [1:0] {
    SEND_IDLE = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } send_state_t;

  main_state_t       main_q, main_d;
  send_state_t       send_q, send_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [16:0]       remaining_q, remaining_d;
  logic [15:0]       len_q, len_d;
  logic              fetch_wait_q, fetch_wait_d;
  logic [16:0]       clamp_count;
  logic              byte_done;
`ifdef SAMPLE_DUMP_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign rd_addr        = addr_q;
  assign tx_data        = tx_byte_q;
  assign done           = (main_q == ST_DONE);
  assign dbg_main_state = main_q;
  assign dbg_send_state = send_q;

  always_comb begin
    if (32'(sample_count) > DEPTH) clamp_count = 17'(DEPTH);
    else                           clamp_count = {1'b0, sample_count};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= ST_IDLE;
      send_q       <= SEND_IDLE;
      tx_byte_q    <= '0;
      addr_q       <= '0;
      remaining_q  <= '0;
      len_q        <= '0;
      fetch_wait_q <= 1'b0;
`ifdef SAMPLE_DUMP_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      main_q       <= main_d;
      send_q       <= send_d;
      tx_byte_q    <= tx_byte_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      len_q        <= len_d;
      fetch_wait_q <= fetch_wait_d;
`ifdef SAMPLE_DUMP_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  // UART handshake: tx_start is a one-cycle request that may only be raised
  // while tx_busy=0; the byte is accepted once tx_busy rises and finished when it falls.
  always_comb begin
    main_d       = main_q;
    send_d       = send_q;
    tx_byte_d    = tx_byte_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    len_d        = len_q;
    fetch_wait_d = fetch_wait_q;
`ifdef SAMPLE_DUMP_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    tx_start     = 1'b0;
    rd_en        = 1'b0;
    byte_done    = 1'b0;

    case (main_q)
      ST_IDLE: begin
        if (activate) begin
          main_d       = ST_HEADER;
          send_d       = SEND_IDLE;
          tx_byte_d    = HEADER;
          addr_d       = start_addr;
          remaining_d  = clamp_count;
          len_d        = clamp_count[15:0];
          fetch_wait_d = 1'b0;
`ifdef SAMPLE_DUMP_CHECKSUM_EN
          csum_d       = '0;
`endif
        end
      end

      ST_FETCH: begin
        if (!fetch_wait_q) begin
          if (!activate) begin
            main_d = ST_IDLE;
          end else begin
            rd_en        = 1'b1;
            fetch_wait_d = 1'b1;
          end
        end else begin
          // Memory answers one cycle after the strobe.
          tx_byte_d    = rd_data;
          addr_d       = addr_q + 1'b1;
          remaining_d  = remaining_q - 17'd1;
          fetch_wait_d = 1'b0;
          main_d       = ST_DATA;
          send_d       = SEND_IDLE;
`ifdef SAMPLE_DUMP_CHECKSUM_EN
          csum_d       = csum_q ^ rd_data;
`endif
        end
      end

      ST_DONE: begin
        if (!activate) main_d = ST_IDLE;
      end

      default: begin
        // Byte-sending states share this sub-FSM.
        case (send_q)
          SEND_IDLE: begin
            if (!activate) begin
              main_d = ST_IDLE;
            end else if (!tx_busy) begin
              tx_start = 1'b1;
              send_d   = WAIT_BUSY;
            end
          end
          WAIT_BUSY: begin
            if (tx_busy) send_d = WAIT_DONE;
          end
          WAIT_DONE: begin
            if (!tx_busy) begin
              send_d    = SEND_IDLE;
              byte_done = 1'b1;
            end
          end
          default: send_d = SEND_IDLE;
        endcase
      end
    endcase

    if (byte_done) begin
      if (!activate) begin
        main_d = ST_IDLE;
      end else begin
        case (main_q)
          ST_HEADER: begin
            main_d    = ST_LEN_HI;
            tx_byte_d = len_q[15:8];
`ifdef SAMPLE_DUMP_CHECKSUM_EN
            csum_d    = csum_q ^ len_q[15:8];
`endif
          end
          ST_LEN_HI: begin
            main_d    = ST_LEN_LO;
            tx_byte_d = len_q[7:0];
`ifdef SAMPLE_DUMP_CHECKSUM_EN
            csum_d    = csum_q ^ len_q[7:0];
`endif
          end
          ST_LEN_LO, ST_DATA: begin
            if (remaining_q == '0) begin
`ifdef SAMPLE_DUMP_CHECKSUM_EN
              main_d    = ST_CSUM;
              tx_byte_d = csum_q;
`else
              main_d    = ST_DONE;
`endif
            end else begin
              main_d       = ST_FETCH;
              fetch_wait_d = 1'b0;
            end
          end
          default: main_d = ST_DONE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_dump_tx.sv
// Directed bench for sample_dump_tx: UART model with 10-cycle busy, sample memory model,
// expected-byte scoreboard and tx protocol monitor.
module tb_sample_dump_tx;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              activate;
  logic              done;
  logic [15:0]       sample_count;
  logic [ADDR_W-1:0] start_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data = 8'h00;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [3:0]        dbg_main_state;
  logic [1:0]        dbg_send_state;

  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  int                busy_cnt = 0;
  logic              prev_start = 1'b0;
  logic [7:0]        exp_q[$];
  logic [7:0]        rx_q[$];
  logic [ADDR_W-1:0] rd_log[$];
  int                checks = 0;
  int                errors = 0;

  sample_dump_tx #(.ADDR_W(ADDR_W), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .activate(activate), .done(done),
    .sample_count(sample_count), .start_addr(start_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .dbg_main_state(dbg_main_state), .dbg_send_state(dbg_send_state)
  );

  // clock / models
  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  always @(posedge clk) begin
    if (tx_start && busy_cnt == 0) busy_cnt <= 10;
    else if (busy_cnt != 0)        busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // monitor: samples mid-cycle
  always @(negedge clk) begin
    if (tx_start) begin
      rx_q.push_back(tx_data);
      checks++;
      assert (!tx_busy && !prev_start) else begin
        errors++;
        $error("FAIL tx_protocol: tx_start with busy=%0b prev_start=%0b, required busy=0 prev_start=0", tx_busy, prev_start);
      end
    end
    prev_start = tx_start;
    if (rd_en) rd_log.push_back(rd_addr);
  end

  // driver / checker tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_frame(input string tag);
    int n;
    chk({tag, "_len"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic start_frame(input logic [15:0] cnt, input logic [ADDR_W-1:0] addr);
    sample_count = cnt;
    start_addr   = addr;
    rx_q.delete();
    rd_log.delete();
    activate = 1'b1;
    tick(1);
    chk("hdr_latency", tx_start, 1'b1);
    chk("hdr_data", tx_data, 8'hA5);
    sample_count = 16'hBEEF;
    start_addr   = 12'h5A5;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_done_reached"}, done, 1'b1);
  endtask

  task automatic end_frame(input string tag);
    activate = 1'b0;
    tick(1);
    chk({tag, "_done_clear"}, done, 1'b0);
    chk({tag, "_idle"}, dbg_main_state, 4'd0);
    tick(1);
  endtask

  initial begin
    logic [7:0] bulk_csum;
    int n;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i * 7 + 3);
    mem[12'hFFE] = 8'h11;
    mem[12'hFFF] = 8'h22;
    mem[12'h000] = 8'h33;

    rst = 1'b1; activate = 1'b0; sample_count = 16'd0; start_addr = '0;
    tick(3);
    chk("rst_done", done, 1'b0);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_rd_addr", rd_addr, 12'h000);
    chk("rst_state", {dbg_main_state, dbg_send_state}, 6'd0);
    rst = 1'b0;
    tick(2);

    // wrapping 3-sample frame
    start_frame(16'd3, 12'hFFE);
    exp_q = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
`ifdef SAMPLE_DUMP_CHECKSUM_EN
    exp_q.push_back(8'h03);
`endif
    wait_done(2000, "t1");
    chk("t1_busy_at_done", tx_busy, 1'b0);
    chk("t1_rd_count", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      chk("t1_rd_addr0", rd_log[0], 12'hFFE);
      chk("t1_rd_addr1", rd_log[1], 12'hFFF);
      chk("t1_rd_addr2", rd_log[2], 12'h000);
    end
    check_frame("t1");
    tick(3);
    chk("t1_done_held", done, 1'b1);
    chk("t1_no_restart", rx_q.size(), 0);
    end_frame("t1");

    // zero-count frame
    start_frame(16'd0, 12'h010);
    exp_q = '{8'hA5, 8'h00, 8'h00};
`ifdef SAMPLE_DUMP_CHECKSUM_EN
    exp_q.push_back(8'h00);
`endif
    wait_done(1000, "t2");
    chk("t2_no_rd", rd_log.size(), 0);
    check_frame("t2");
    end_frame("t2");

    // abort during the second data byte
    start_frame(16'd3, 12'hFFE);
    n = 0;
    while (rx_q.size() < 5 && n < 2000) begin
      tick(1);
      n++;
    end
    chk("t4_reached_byte5", rx_q.size(), 5);
    activate = 1'b0;
    tick(1);
    chk("t4_busy_in_flight", tx_busy, 1'b1);
    chk("t4_still_data", dbg_main_state, 4'd5);
    n = 0;
    while (tx_busy !== 1'b0 && n < 50) begin
      tick(1);
      n++;
    end
    chk("t4_busy_fell", tx_busy, 1'b0);
    tick(1);
    chk("t4_idle", dbg_main_state, 4'd0);
    chk("t4_done_low", done, 1'b0);
    tick(30);
    exp_q = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22};
    check_frame("t4");
    chk("t4_done_still_low", done, 1'b0);

    // reset while the header is in flight
    start_frame(16'd3, 12'hFFE);
    tick(2);
    chk("t5_in_wait_done", {dbg_main_state, dbg_send_state}, {4'd1, 2'd2});
    sample_count = 16'd3;
    start_addr   = 12'hFFE;
    rst = 1'b1;
    tick(1);
    chk("t5_rst_tx_start", tx_start, 1'b0);
    chk("t5_rst_tx_data", tx_data, 8'h00);
    chk("t5_rst_rd_en", rd_en, 1'b0);
    chk("t5_rst_rd_addr", rd_addr, 12'h000);
    chk("t5_rst_done", done, 1'b0);
    chk("t5_rst_state", dbg_main_state, 4'd0);
    rx_q.delete();
    rd_log.delete();
    rst = 1'b0;
    exp_q = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
`ifdef SAMPLE_DUMP_CHECKSUM_EN
    exp_q.push_back(8'h03);
`endif
    wait_done(2000, "t5");
    check_frame("t5");
    end_frame("t5");

    // clamped full-buffer frame with wrap
    start_frame(16'h2000, 12'h123);
    exp_q = '{8'hA5, 8'h10, 8'h00};
    bulk_csum = 8'h10;
    for (int k = 0; k < (1 << ADDR_W); k++) begin
      exp_q.push_back(mem[12'h123 + 12'(k)]);
      bulk_csum = bulk_csum ^ mem[12'h123 + 12'(k)];
    end
`ifdef SAMPLE_DUMP_CHECKSUM_EN
    exp_q.push_back(bulk_csum);
`endif
    wait_done(70000, "t3");
    chk("t3_rd_count", rd_log.size(), 4096);
    if (rd_log.size() == 4096) begin
      chk("t3_rd_first", rd_log[0], 12'h123);
      chk("t3_rd_last", rd_log[4095], 12'h122);
    end
    chk("t3_addr_wrapped", rd_addr, 12'h123);
    check_frame("t3");
    end_frame("t3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
